pipe_stage_buf: RTL and testbench

//  Parametrised elastic pipeline-stage register for the multi-core pipeline, replacing fixed per-stage latches.

---
 rtl/pipe_stage_buf_pkg.sv | 14 +
 rtl/pipe_stage_buf_if.sv | 16 +
 rtl/pipe_stage_buf_slot.sv | 72 +++++++
 rtl/pipe_stage_buf.sv | 88 ++++++++
 tb/tb_pipe_stage_buf.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the elastic pipeline-stage buffer.
// The memop bit positions also tell a slot which bits a dcache hit may clear.
package pipe_stage_buf_pkg;

   typedef logic [1:0] pipe_occ_t;

   localparam int unsigned MEMOP_DWEN = 1;
   localparam int unsigned MEMOP_DREN = 0;

   function automatic pipe_occ_t occ_of(input logic head_v, input logic skid_v);
      return pipe_occ_t'({1'b0, head_v}) + pipe_occ_t'({1'b0, skid_v});
   endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready bundle between two pipeline stages.
// The producer side uses master and the consumer side uses slave.
interface pipe_stage_buf_if #(
   parameter int DATA_W  = 128,
   parameter int CTRL_W  = 16,
   parameter int MEMOP_W = 2
);
   logic               valid;
   logic               ready;
   logic [DATA_W-1:0]  data;
   logic [CTRL_W-1:0]  ctrl;
   logic [MEMOP_W-1:0] memop;

   modport master (output valid, data, ctrl, memop, input ready);
   modport slave  (input valid, data, ctrl, memop, output ready);
endinterface

// File: rtl/pipe_stage_buf_slot.sv
// One buffer entry {valid,data,ctrl,memop}.
// Priority: clear (flush) > load > drop (popped, not refilled) > memop_clr (dhit).
module pipe_slot #(
   parameter int                  DATA_W   = 128,
   parameter int                  CTRL_W   = 16,
   parameter int                  MEMOP_W  = 2,
   parameter logic [MEMOP_W-1:0]  CLR_MASK = '1
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               load,
   input  logic               clear,
   input  logic               drop,
   input  logic               memop_clr,
   input  logic [DATA_W-1:0]  ld_data,
   input  logic [CTRL_W-1:0]  ld_ctrl,
   input  logic [MEMOP_W-1:0] ld_memop,
   output logic               valid,
   output logic [DATA_W-1:0]  data,
   output logic [CTRL_W-1:0]  ctrl,
   output logic [MEMOP_W-1:0] memop
);

   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  data_q,  data_d;
   logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
   logic [MEMOP_W-1:0] memop_q, memop_d;

   // NOTE: every _d starts as its _q so no path through this block can infer a latch.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      memop_d = memop_q;
      if (clear) begin
         valid_d = 1'b0;
         data_d  = '0;
         ctrl_d  = '0;
         memop_d = '0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = ld_data;
         ctrl_d  = ld_ctrl;
         memop_d = ld_memop;
      end else if (drop) begin
         valid_d = 1'b0;
      end else if (memop_clr && valid_q) begin
         memop_d = memop_q & ~CLR_MASK;
      end
   end

   // NOTE: state flops use non-blocking assignments so all entries update from pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
         memop_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         memop_q <= memop_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign ctrl  = ctrl_q;
   assign memop = memop_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: head slot plus optional skid slot, flush,
// dhit clearing of the head memop, and a saturating back-pressure counter.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W  = 128,
   parameter int CTRL_W  = 16,
   parameter int MEMOP_W = 2,
   parameter bit SKID    = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   pipe_stage_buf_if.slave   in_if,
   pipe_stage_buf_if.master  out_if,
   input  logic              flush,
   input  logic              dhit,
   output pipe_occ_t         occ,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [MEMOP_W-1:0] REQ_MASK =
      MEMOP_W'((1 << MEMOP_DWEN) | (1 << MEMOP_DREN));

   logic               in_ready, push, pop;
   logic               head_load, skid_load, skid_drop;
   logic               head_v, skid_v;
   logic [DATA_W-1:0]  head_data,  skid_data,  head_ld_data;
   logic [CTRL_W-1:0]  head_ctrl,  skid_ctrl,  head_ld_ctrl;
   logic [MEMOP_W-1:0] head_memop, skid_memop, head_ld_memop;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   // Head refills from skid first so FIFO order holds; otherwise straight from upstream.
   always_comb begin
      push          = in_if.valid && in_ready;
      pop           = head_v && out_if.ready;
      head_load     = (pop && skid_v) || (push && (!head_v || pop));
      skid_load     = push && head_v && !pop;
      skid_drop     = pop && skid_v;
      head_ld_data  = skid_v ? skid_data  : in_if.data;
      head_ld_ctrl  = skid_v ? skid_ctrl  : in_if.ctrl;
      head_ld_memop = skid_v ? skid_memop : in_if.memop;
   end

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .MEMOP_W(MEMOP_W), .CLR_MASK(REQ_MASK)) u_head (
      .CLK(CLK), .nRST(nRST), .load(head_load), .clear(flush), .drop(pop), .memop_clr(dhit),
      .ld_data(head_ld_data), .ld_ctrl(head_ld_ctrl), .ld_memop(head_ld_memop),
      .valid(head_v), .data(head_data), .ctrl(head_ctrl), .memop(head_memop)
   );

   generate
      if (SKID) begin : g_skid
         pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .MEMOP_W(MEMOP_W), .CLR_MASK(REQ_MASK)) u_skid (
            .CLK(CLK), .nRST(nRST), .load(skid_load), .clear(flush), .drop(skid_drop), .memop_clr(1'b0),
            .ld_data(in_if.data), .ld_ctrl(in_if.ctrl), .ld_memop(in_if.memop),
            .valid(skid_v), .data(skid_data), .ctrl(skid_ctrl), .memop(skid_memop)
         );
         // Registered ready: no combinational path from out_ready back upstream.
         assign in_ready = !skid_v;
      end else begin : g_noskid
         assign skid_v     = 1'b0;
         assign skid_data  = '0;
         assign skid_ctrl  = '0;
         assign skid_memop = '0;
         assign in_ready   = !head_v || out_if.ready;
      end
   endgenerate

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (head_v && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign in_if.ready  = in_ready;
   assign out_if.valid = head_v;
   assign out_if.data  = head_data;
   assign out_if.ctrl  = head_ctrl;
   assign out_if.memop = head_memop;
   assign occ          = occ_of(head_v, skid_v);
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboarded bench for pipe_stage_buf: SKID=1 instance checked by a monitor,
// plus a SKID=0 / CNT_W=4 instance checked directly for comb ready and saturation.
module tb_pipe_stage_buf;
   import pipe_stage_buf_pkg::*;

   typedef struct packed {
      logic [127:0] data;
      logic [15:0]  ctrl;
      logic [1:0]   memop;
   } exp_t;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        flush, dhit, flush2, dhit2;
   pipe_occ_t   occ, occ2;
   logic [15:0] stall_cnt;
   logic [3:0]  stall_cnt2;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];
   logic [15:0] stall_exp;

   pipe_stage_buf_if #(.DATA_W(128), .CTRL_W(16), .MEMOP_W(2)) up(), dn(), up2(), dn2();

   pipe_stage_buf #(.DATA_W(128), .CTRL_W(16), .MEMOP_W(2), .SKID(1'b1), .CNT_W(16)) dut (
      .CLK(CLK), .nRST(nRST), .in_if(up), .out_if(dn),
      .flush(flush), .dhit(dhit), .occ(occ), .stall_cnt(stall_cnt)
   );

   pipe_stage_buf #(.DATA_W(128), .CTRL_W(16), .MEMOP_W(2), .SKID(1'b0), .CNT_W(4)) dut4 (
      .CLK(CLK), .nRST(nRST), .in_if(up2), .out_if(dn2),
      .flush(flush2), .dhit(dhit2), .occ(occ2), .stall_cnt(stall_cnt2)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the registered state against the queue, then applies this edge's updates.
   always @(negedge CLK) begin
      if (!nRST) begin
         q.delete();
         stall_exp = '0;
      end else begin
         check("out_valid", 128'(dn.valid), 128'(q.size() != 0));
         check("occ",       128'(occ),      128'(q.size()));
         check("in_ready",  128'(up.ready), 128'(q.size() < 2));
         check("stall_cnt", 128'(stall_cnt), 128'(stall_exp));
         if (q.size() != 0) begin
            check("out_data",  dn.data,         q[0].data);
            check("out_ctrl",  128'(dn.ctrl),   128'(q[0].ctrl));
            check("out_memop", 128'(dn.memop),  128'(q[0].memop));
            if (!dn.ready && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
         end
         if (flush)                          q.delete();
         else if (q.size() != 0 && dn.ready) void'(q.pop_front());
         else if (dhit && q.size() != 0)     q[0].memop = 2'b00;
      end
   end

   // One cycle of main-DUT stimulus; acc is the hand-decided acceptance of the offered bundle.
   task automatic cyc(input logic iv, input logic [127:0] d, input logic [15:0] c, input logic [1:0] m,
                      input logic ordy, input logic fl, input logic dh, input logic acc);
      up.valid = iv; up.data = d; up.ctrl = c; up.memop = m;
      dn.ready = ordy; flush = fl; dhit = dh;
      @(negedge CLK); #1;
      if (acc) q.push_back({d, c, m});
      @(posedge CLK); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 128'h0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_valid"}, 128'(dn.valid), 128'h0);
      check({tag, "_occ"},   128'(occ),      128'h0);
      check({tag, "_ctrl"},  128'(dn.ctrl),  128'h0);
      check({tag, "_memop"}, 128'(dn.memop), 128'h0);
      check({tag, "_data"},  dn.data,        128'h0);
      check({tag, "_rdy"},   128'(up.ready), 128'h1);
   endtask

   initial begin
      nRST = 1'b0;
      up.valid = 1'b0; up.data = '0; up.ctrl = '0; up.memop = '0; dn.ready = 1'b0;
      up2.valid = 1'b0; up2.data = '0; up2.ctrl = '0; up2.memop = '0; dn2.ready = 1'b0;
      flush = 1'b0; dhit = 1'b0; flush2 = 1'b0; dhit2 = 1'b0;
      #1;
      check_empty("rst0");
      check("rst0_stall",  128'(stall_cnt),  128'h0);
      check("rst0_valid2", 128'(dn2.valid),  128'h0);
      check("rst0_occ2",   128'(occ2),       128'h0);
      check("rst0_stall2", 128'(stall_cnt2), 128'h0);
      #11 nRST = 1'b1;
      @(posedge CLK); #1;

      // Pass-through 0x1..0x5 back to back
      for (int i = 1; i <= 5; i++)
         cyc(1'b1, 128'(i), 16'(i + 16'h10), 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Backpressure: 0xA head, 0xB skid, then buffer full
      cyc(1'b1, 128'hA,  16'h00A1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 128'hB,  16'h00B1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 128'hEE, 16'h00EE, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 128'hEE, 16'h00EE, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("t3_stall_cnt", 128'(stall_cnt), 128'd3);

      // Flush with full buffer, then flush while a push would be accepted
      cyc(1'b1, 128'h21, 16'h5A5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 128'h22, 16'hA5A5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 128'hC,  16'hCCCC, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      check_empty("fl1");
      cyc(1'b1, 128'h31, 16'h3131, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 128'hC,  16'hCCCC, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      check_empty("fl2");
      idle(2);

      // dhit on stalled head, then dhit coinciding with pop, then dhit on empty
      cyc(1'b1, 128'h41, 16'h0041, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 128'h42, 16'h0042, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 128'h0,  16'h0,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 128'h0,  16'h0,    2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 128'h0,  16'h0,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 128'h0,  16'h0,    2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 128'h0,  16'h0,    2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 128'h43, 16'h0043, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Async reset with occ=2
      cyc(1'b1, 128'h51, 16'h0051, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 128'h52, 16'h0052, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
      check("pre_rst_occ", 128'(occ), 128'd2);
      up.valid = 1'b0;
      nRST = 1'b0;
      #1;
      check_empty("rst1");
      check("rst1_stall", 128'(stall_cnt), 128'h0);
      @(negedge CLK);
      @(posedge CLK); #1;
      nRST = 1'b1;
      #1;
      check("rst1_rdy_after", 128'(up.ready), 128'h1);
      idle(2);

      // SKID=0, CNT_W=4: combinational ready, single entry, counter saturation
      up2.valid = 1'b1; up2.data = 128'h61; up2.ctrl = 16'h0061; dn2.ready = 1'b0;
      #1 check("s0_rdy_empty", 128'(up2.ready), 128'h1);
      @(posedge CLK); #1;
      up2.data = 128'h62; up2.ctrl = 16'h0062;
      #1 check("s0_rdy_stall", 128'(up2.ready), 128'h0);
      check("s0_occ1", 128'(occ2), 128'd1);
      dn2.ready = 1'b1;
      #1 check("s0_rdy_comb", 128'(up2.ready), 128'h1);
      dn2.ready = 1'b0;
      #1;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         check("s0_occ_max", 128'(occ2 <= 2'd1), 128'h1);
      end
      check("s0_stall_sat", 128'(stall_cnt2), 128'd15);
      check("s0_hold_data", dn2.data, 128'h61);
      dn2.ready = 1'b1;
      @(posedge CLK); #1;
      check("s0_next_data", dn2.data, 128'h62);
      check("s0_next_ctrl", 128'(dn2.ctrl), 128'h0062);
      up2.valid = 1'b0;
      @(posedge CLK); #1;
      check("s0_drained", 128'(dn2.valid), 128'h0);
      check("s0_occ0",    128'(occ2),      128'h0);
      check("s0_sat_keep", 128'(stall_cnt2), 128'd15);

      check("sb_drained", 128'(q.size()), 128'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
